// File: rtl/pc_unit.sv
// Registered program counter with sequential/branch/jump/call/return/trap
// next-PC selection, stall hold and a circular return-address stack.
//
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   STALL            hold PC, RAS and flags this cycle
//   BR_TAKEN         PC-relative branch by BR_OFFSET
//   JMP, CALL        absolute jump to JMP_TARGET (CALL also pushes PC+STEP)
//   RET              pop RAS and jump to the popped address
//   TRAP             jump to TRAP_VECTOR
//   PC, PC_PLUS      current PC and PC+STEP link value
//   RAS_EMPTY/FULL   RAS occupancy status
//   RAS_OFLOW/UFLOW  sticky overflow/underflow flags
//   MISALIGN         low PC bits are not zero
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int               STEP         = 4,
    parameter int               ALIGN_BITS   = 2,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_OFFSET,
    input  logic             JMP,
    input  logic             CALL,
    input  logic [WIDTH-1:0] JMP_TARGET,
    input  logic             RET,
    input  logic             TRAP,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_PLUS,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             RAS_OFLOW,
    output logic             RAS_UFLOW,
    output logic             MISALIGN
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PMAX = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top_q;
    logic [PW-1:0]    top_d;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             oflow_q;
    logic             oflow_d;
    logic             uflow_q;
    logic             uflow_d;
    logic             push;
    logic             empty;
    logic             full;

    assign pc_plus = pc_q + WIDTH'(STEP);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CMAX);

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign top_inc = (top_q == PMAX) ? '0 : top_q + PW'(1);
    assign top_dec = (top_q == '0) ? PMAX : top_q - PW'(1);

    always_comb begin
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        oflow_d = oflow_q;
        uflow_d = uflow_q;
        push    = 1'b0;
        if (!STALL) begin
            if (TRAP) begin
                pc_d = TRAP_VECTOR;
            end else if (RET) begin
                if (!empty) begin
                    pc_d  = ras[top_q];
                    cnt_d = cnt_q - CW'(1);
                    top_d = top_dec;
                end else begin
                    pc_d    = pc_plus;
                    uflow_d = 1'b1;
                end
            end else if (CALL) begin
                // When full, the slot after top is the oldest entry,
                // so the push overwrites it and the count saturates.
                pc_d  = JMP_TARGET;
                push  = 1'b1;
                top_d = top_inc;
                if (full) begin
                    oflow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (JMP) begin
                pc_d = JMP_TARGET;
            end else if (BR_TAKEN) begin
                pc_d = pc_q + BR_OFFSET;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            cnt_q   <= '0;
            oflow_q <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            oflow_q <= oflow_d;
            uflow_q <= uflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            ras[top_inc] <= pc_plus;
        end
    end

    assign PC        = pc_q;
    assign PC_PLUS   = pc_plus;
    assign RAS_EMPTY = empty;
    assign RAS_FULL  = full;
    assign RAS_OFLOW = oflow_q;
    assign RAS_UFLOW = uflow_q;
    assign MISALIGN  = |pc_q[ALIGN_BITS-1:0];

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit for the single-cycle CPU, replacing the combinational reset mux in front of instruction fetch.
- Holds the current PC and computes the next PC each clock from sequential, branch, jump, call, return and trap requests, with a stall hold.
- Contains a parametrised return-address stack (RAS) for CALL/RET.
- Drives the instruction memory address and the PC+STEP link value.

Parameters:
- WIDTH, 32, PC and address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, PC value loaded on TRAP.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero.
- RAS_DEPTH, 4, return-address stack entries (>=2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- STALL  in  1  hold PC and RAS unchanged this cycle.
- BR_TAKEN  in  1  take a PC-relative branch.
- BR_OFFSET  in  WIDTH  signed byte offset, added to the current PC.
- JMP  in  1  absolute jump to JMP_TARGET.
- CALL  in  1  jump to JMP_TARGET and push PC+STEP.
- JMP_TARGET  in  WIDTH  absolute target for JMP and CALL.
- RET  in  1  pop the RAS and jump to the popped address.
- TRAP  in  1  jump to TRAP_VECTOR.
- PC  out  WIDTH  current PC (registered).
- PC_PLUS  out  WIDTH  PC+STEP (combinational from PC), used as the link value.
- RAS_EMPTY  out  1  RAS count == 0.
- RAS_FULL  out  1  RAS count == RAS_DEPTH.
- RAS_OFLOW  out  1  sticky: a CALL was made while the RAS was full.
- RAS_UFLOW  out  1  sticky: a RET was made while the RAS was empty.
- MISALIGN  out  1  PC[ALIGN_BITS-1:0] != 0 (combinational from PC).

Behaviour:
- Reset (async, any time, including mid-stall or mid-call):
  - PC = RESET_VECTOR.
  - RAS count = 0, top pointer = 0.
  - RAS_OFLOW = RAS_UFLOW = 0.
  - RAS contents are don't-care.
  - Outputs take their reset values immediately, without waiting for a clock edge.
- The first rising edge after RST deasserts performs a normal update.
- Latency: a request sampled at edge N is visible on PC after edge N; PC_PLUS and MISALIGN follow in the same cycle.
- Priority per edge, highest first:
  1. STALL: PC, RAS and flags hold; all other requests are ignored (no push, no pop).
  2. TRAP: PC = TRAP_VECTOR; RAS unchanged.
  3. RET:
     - RAS not empty: PC = top entry; count-1; top pointer-1 (mod RAS_DEPTH).
     - RAS empty: PC = PC+STEP; RAS_UFLOW set; count stays 0.
  4. CALL (JMP is ignored when CALL is also asserted):
     - PC = JMP_TARGET; push PC+STEP at top pointer+1 (mod RAS_DEPTH).
     - RAS full: the push overwrites the oldest entry (circular); count saturates at RAS_DEPTH; RAS_OFLOW set.
  5. JMP: PC = JMP_TARGET.
  6. BR_TAKEN: PC = PC + BR_OFFSET (two's complement, modulo 2^WIDTH).
  7. Otherwise: PC = PC + STEP (modulo 2^WIDTH; wraps from all-ones region to 0, no flag).
- Lower-priority requests in the same cycle are dropped, not queued.
- Sticky flags clear only on RST.
- RAS is a circular buffer:
  - Entry storage has no reset.
  - The pointer wraps modulo RAS_DEPTH.
  - Count ranges 0..RAS_DEPTH.
- Targets are not validated. A misaligned target is loaded as given, and MISALIGN reports it.
- No combinational path from request inputs to PC, RAS_EMPTY or RAS_FULL; all three are registered-state derived.

Test Plan:
- Reset: assert RST between edges with PC=0x40 -> PC=0x0000_0000 immediately, before any edge. Release RST, 3 idle edges -> PC = 0x4, 0x8, 0xC.
- Branch and wrap:
  - PC=0x100, BR_TAKEN, BR_OFFSET=0xFFFF_FFF0 -> PC=0xF0.
  - PC=0xFFFF_FFFC, idle edge -> PC=0x0.
- Stall and priority:
  - PC=0x20, STALL with TRAP/CALL/BR asserted -> PC stays 0x20, RAS count unchanged.
  - Next edge with TRAP+JMP -> PC=0x80.
- Call/return nesting:
  - PC=0x10, CALL to 0x200 -> PC=0x200, RAS top=0x14.
  - CALL to 0x300 -> PC=0x300, RAS top=0x204.
  - Two RETs -> PC=0x204 then PC=0x14; RAS_EMPTY=1.
- Overflow/underflow, RAS_DEPTH=4:
  - 5 CALLs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> RAS_FULL=1, RAS_OFLOW=1.
  - 4 RETs -> PC = 0x404, 0x304, 0x204, 0x104 (0x4 was lost).
  - 5th RET with RAS empty -> PC=0x108, RAS_UFLOW=1.
- Misalign and reset mid-call:
  - JMP to 0x202 -> PC=0x202, MISALIGN=1.
  - Then CALL to 0x400 followed by RST before the next edge -> PC=0x0, RAS_EMPTY=1, both sticky flags 0.
